// File: rtl/mandel_pixel_writer_pkg.sv
// Shared constants, FSM state type and colour mapping for the Mandelbrot pixel writer.
package mandel_pixel_writer_pkg;

    localparam int unsigned GEOM_WIDTH_PX       = 320;
    localparam int unsigned GEOM_HEIGHT_PX      = 240;
    localparam int unsigned GEOM_LINES_PER_BANK = 16;
    localparam int unsigned GEOM_BANKS          = 15;

    localparam int unsigned COORD_WIDTH = 18;
    localparam int unsigned FRAC_BITS   = 13;
    localparam int unsigned DATA_WIDTH  = 12;
    localparam int unsigned ITER_WIDTH  = 8;
    localparam int unsigned MAX_ITER    = 63;

    localparam int unsigned ESCAPE_LIMIT = 4 << FRAC_BITS;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ITER,
        WRITE,
        DONE
    } state_e;

    // Points that never escaped are painted black; others get an RGB444 band colour.
    function automatic logic [DATA_WIDTH-1:0] colour_map(input logic [ITER_WIDTH-1:0] iter);
        if (iter == ITER_WIDTH'(MAX_ITER)) begin
            return '0;
        end
        return {iter[3:0], iter[5:4], iter[1:0], ~iter[3:0]};
    endfunction

endpackage

// File: rtl/mandel_pixel_writer_iter_core.sv
// One escape-time step: holds z, computes the squared magnitude test and the z update.
module mandel_pixel_writer_iter_core
    import mandel_pixel_writer_pkg::*;
(
    input  logic                   clk,
    input  logic                   i_reset,
    input  logic                   i_clear,
    input  logic                   i_update,
    input  logic [COORD_WIDTH-1:0] i_cr,
    input  logic [COORD_WIDTH-1:0] i_ci,
    output logic                   o_escape
);

    localparam int unsigned PROD_W = 2 * COORD_WIDTH;
    localparam int unsigned MAG_W  = COORD_WIDTH + 2;
    localparam logic signed [MAG_W-1:0] LIMIT = MAG_W'(ESCAPE_LIMIT);

    logic signed [COORD_WIDTH-1:0] r_zr;
    logic signed [COORD_WIDTH-1:0] r_zi;

    logic signed [PROD_W-1:0]      w_zr_ext;
    logic signed [PROD_W-1:0]      w_zi_ext;
    logic signed [PROD_W-1:0]      w_prod_rr;
    logic signed [PROD_W-1:0]      w_prod_ii;
    logic signed [PROD_W-1:0]      w_prod_ri;
    logic signed [MAG_W-1:0]       w_zr2;
    logic signed [MAG_W-1:0]       w_zi2;
    logic signed [MAG_W-1:0]       w_mag;
    logic signed [COORD_WIDTH-1:0] w_zri;
    logic signed [COORD_WIDTH-1:0] w_zr_next;
    logic signed [COORD_WIDTH-1:0] w_zi_next;

    always_comb begin
        w_zr_ext  = PROD_W'(r_zr);
        w_zi_ext  = PROD_W'(r_zi);
        w_prod_rr = w_zr_ext * w_zr_ext;
        w_prod_ii = w_zi_ext * w_zi_ext;
        w_prod_ri = w_zr_ext * w_zi_ext;
        w_zr2     = MAG_W'(w_prod_rr >>> FRAC_BITS);
        w_zi2     = MAG_W'(w_prod_ii >>> FRAC_BITS);
        // 2*zr*zi folded into the shift amount
        w_zri     = COORD_WIDTH'(w_prod_ri >>> (FRAC_BITS - 1));
        w_mag     = w_zr2 + w_zi2;
        w_zr_next = COORD_WIDTH'(w_zr2 - w_zi2 + MAG_W'($signed(i_cr)));
        w_zi_next = w_zri + $signed(i_ci);
        o_escape  = (w_mag >= LIMIT);
    end

    always_ff @(posedge clk) begin
        if (i_reset || i_clear) begin
            r_zr <= '0;
            r_zi <= '0;
        end else if (i_update) begin
            r_zr <= w_zr_next;
            r_zi <= w_zi_next;
        end
    end

endmodule

// File: rtl/mandel_pixel_writer.sv
// Walks the frame pixel by pixel, runs the escape-time iteration and writes RGB444 words
// into the banked line buffers.
module mandel_pixel_writer
    import mandel_pixel_writer_pkg::*;
#(
    parameter int unsigned WIDTH_PX       = GEOM_WIDTH_PX,
    parameter int unsigned HEIGHT_PX      = GEOM_HEIGHT_PX,
    parameter int unsigned LINES_PER_BANK = GEOM_LINES_PER_BANK,
    parameter int unsigned ADDR_WIDTH     = 13
) (
    input  logic                   clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_start,
    input  logic [COORD_WIDTH-1:0] i_x0,
    input  logic [COORD_WIDTH-1:0] i_y0,
    input  logic [COORD_WIDTH-1:0] i_step,
    output logic [3:0]             o_bank,
    output logic [ADDR_WIDTH-1:0]  o_addr,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_write,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned BANKS  = HEIGHT_PX / LINES_PER_BANK;
    localparam int unsigned X_W    = (WIDTH_PX > 1) ? $clog2(WIDTH_PX) : 1;
    localparam int unsigned LINE_W = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1;

    state_e r_state;
    state_e w_state_d;

    logic [COORD_WIDTH-1:0] r_x0;
    logic [COORD_WIDTH-1:0] r_step;
    logic [COORD_WIDTH-1:0] r_cr;
    logic [COORD_WIDTH-1:0] r_ci;
    logic [ITER_WIDTH-1:0]  r_iter;
    logic [X_W-1:0]         r_x;
    logic [LINE_W-1:0]      r_line;
    logic [ADDR_WIDTH-1:0]  r_line_base;
    logic [3:0]             r_bank;

    logic [3:0]             r_out_bank;
    logic [ADDR_WIDTH-1:0]  r_out_addr;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic                   r_write;
    logic                   r_busy;
    logic                   r_done;

    logic w_escape;
    logic w_iter_cap;
    logic w_stop;
    logic w_last_x;
    logic w_last_line;
    logic w_last_pix;
    logic w_core_clear;
    logic w_core_update;

    always_comb begin
        w_iter_cap    = (r_iter == ITER_WIDTH'(MAX_ITER));
        w_stop        = w_escape || w_iter_cap;
        w_last_x      = (r_x == X_W'(WIDTH_PX - 1));
        w_last_line   = (r_line == LINE_W'(LINES_PER_BANK - 1));
        w_last_pix    = w_last_x && w_last_line && (r_bank == 4'(BANKS - 1));
        w_core_clear  = i_enable && (r_state == INIT);
        w_core_update = i_enable && (r_state == ITER) && !w_stop;
    end

    mandel_pixel_writer_iter_core u_core (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_clear  (w_core_clear),
        .i_update (w_core_update),
        .i_cr     (r_cr),
        .i_ci     (r_ci),
        .o_escape (w_escape)
    );

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (i_enable) begin
            case (r_state)
                IDLE:    if (i_start) w_state_d = INIT;
                INIT:    w_state_d = ITER;
                ITER:    if (w_stop) w_state_d = WRITE;
                WRITE:   w_state_d = w_last_pix ? DONE : INIT;
                DONE:    w_state_d = IDLE;
                default: w_state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_x0        <= '0;
            r_step      <= '0;
            r_cr        <= '0;
            r_ci        <= '0;
            r_iter      <= '0;
            r_x         <= '0;
            r_line      <= '0;
            r_line_base <= '0;
            r_bank      <= '0;
            r_out_bank  <= '0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_write     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Strobes last one clock even when the enable is low on the next cycle
            r_write <= 1'b0;
            r_done  <= 1'b0;
            if (i_enable) begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_x0        <= i_x0;
                            r_step      <= i_step;
                            r_cr        <= i_x0;
                            r_ci        <= i_y0;
                            r_x         <= '0;
                            r_line      <= '0;
                            r_line_base <= '0;
                            r_bank      <= '0;
                            r_busy      <= 1'b1;
                        end
                    end
                    INIT: r_iter <= '0;
                    ITER: if (!w_stop) r_iter <= r_iter + ITER_WIDTH'(1);
                    WRITE: begin
                        r_out_bank <= r_bank;
                        r_out_addr <= r_line_base + ADDR_WIDTH'(r_x);
                        r_out_data <= colour_map(r_iter);
                        r_write    <= 1'b1;
                        if (w_last_x) begin
                            r_x  <= '0;
                            r_cr <= r_x0;
                            r_ci <= r_ci - r_step;
                            if (w_last_line) begin
                                r_line      <= '0;
                                r_line_base <= '0;
                                r_bank      <= r_bank + 4'd1;
                            end else begin
                                r_line      <= r_line + LINE_W'(1);
                                r_line_base <= r_line_base + ADDR_WIDTH'(WIDTH_PX);
                            end
                        end else begin
                            r_x  <= r_x + X_W'(1);
                            r_cr <= r_cr + r_step;
                        end
                    end
                    DONE: begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_bank  = r_out_bank;
    assign o_addr  = r_out_addr;
    assign o_data  = r_out_data;
    assign o_write = r_write;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_mandel_pixel_writer.sv
// Randomized self-checking bench for mandel_pixel_writer against an arithmetic Mandelbrot model.
module tb_mandel_pixel_writer;

    typedef struct packed {
        logic [3:0]  bank;
        logic [12:0] addr;
        logic [11:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [17:0] x0, y0, step;
    logic        s_start, m_start, f_start;
    logic [3:0]  s_bank, m_bank, f_bank;
    logic [12:0] s_addr, m_addr, f_addr;
    logic [11:0] s_data, m_data, f_data;
    logic        s_write, m_write, f_write;
    logic        s_busy, m_busy, f_busy;
    logic        s_done, m_done, f_done;

    wr_t q_s[$];
    wr_t q_m[$];
    wr_t q_f[$];
    wr_t exp_q[$];
    int  n_done_s, n_done_m, n_done_f, n_wide_m;
    logic m_write_prev;
    int  tests_run, tests_failed;
    logic [17:0] ax0, ay0, astep;

    // Tiny 4x2 frame, one line per bank
    mandel_pixel_writer #(.WIDTH_PX(4), .HEIGHT_PX(2), .LINES_PER_BANK(1)) u_s (
        .clk(clk), .i_reset(rst), .i_enable(en), .i_start(s_start),
        .i_x0(x0), .i_y0(y0), .i_step(step),
        .o_bank(s_bank), .o_addr(s_addr), .o_data(s_data),
        .o_write(s_write), .o_busy(s_busy), .o_done(s_done)
    );

    // 4x32 frame, two banks of 16 lines
    mandel_pixel_writer #(.WIDTH_PX(4), .HEIGHT_PX(32), .LINES_PER_BANK(16)) u_m (
        .clk(clk), .i_reset(rst), .i_enable(en), .i_start(m_start),
        .i_x0(x0), .i_y0(y0), .i_step(step),
        .o_bank(m_bank), .o_addr(m_addr), .o_data(m_data),
        .o_write(m_write), .o_busy(m_busy), .o_done(m_done)
    );

    mandel_pixel_writer u_f (
        .clk(clk), .i_reset(rst), .i_enable(en), .i_start(f_start),
        .i_x0(x0), .i_y0(y0), .i_step(step),
        .o_bank(f_bank), .o_addr(f_addr), .o_data(f_data),
        .o_write(f_write), .o_busy(f_busy), .o_done(f_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_done_s = 0; n_done_m = 0; n_done_f = 0; n_wide_m = 0; m_write_prev = 1'b0;
    end

    always @(negedge clk) begin
        if (s_write) q_s.push_back({s_bank, s_addr, s_data});
        if (m_write) q_m.push_back({m_bank, m_addr, m_data});
        if (f_write) q_f.push_back({f_bank, f_addr, f_data});
        if (s_done) n_done_s <= n_done_s + 1;
        if (m_done) n_done_m <= n_done_m + 1;
        if (f_done) n_done_f <= n_done_f + 1;
        if (m_write && m_write_prev) n_wide_m <= n_wide_m + 1;
        m_write_prev <= m_write;
    end

    function automatic longint wrapn(input longint v, input int n);
        longint m;
        m = v & ((longint'(1) << n) - 1);
        if (m >= (longint'(1) << (n - 1))) m = m - (longint'(1) << n);
        return m;
    endfunction

    // Escape-time iteration on plain integers in Q4.13, squares compared against 4.0
    function automatic logic [11:0] model_colour(input longint cr, input longint ci);
        longint zr, zi, zr2, zi2, zri;
        int it;
        bit fin;
        zr = 0; zi = 0; it = 0; fin = 0;
        while (!fin) begin
            zr2 = (zr * zr) >>> 13;
            zi2 = (zi * zi) >>> 13;
            zri = (zr * zi) >>> 12;
            if (wrapn(zr2 + zi2, 20) >= 32768 || it == 63) begin
                fin = 1;
            end else begin
                zr = wrapn(zr2 - zi2 + cr, 18);
                zi = wrapn(zri + ci, 18);
                it++;
            end
        end
        if (it == 63) return 12'h000;
        return 12'((it % 16) * 256 + (((it / 16) % 4) * 4 + it % 4) * 16 + (15 - it % 16));
    endfunction

    task automatic build_exp(input int w, input int h, input int lpb,
                             input logic [17:0] bx0, input logic [17:0] by0,
                             input logic [17:0] bstep);
        wr_t e;
        longint cr, ci;
        exp_q.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                cr = wrapn(longint'($signed(bx0)) + longint'(x) * longint'(bstep), 18);
                ci = wrapn(longint'($signed(by0)) - longint'(y) * longint'(bstep), 18);
                e.bank = 4'(y / lpb);
                e.addr = 13'((y % lpb) * w + x);
                e.data = model_colour(cr, ci);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input int which);
        if (which == 0) s_start = 1'b1;
        else if (which == 1) m_start = 1'b1;
        else f_start = 1'b1;
        tick();
        s_start = 1'b0; m_start = 1'b0; f_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic rand_coords();
        int v;
        v = -16384 + int'($urandom_range(18000, 0));
        ax0 = 18'(v);
        v = 7000 + int'($urandom_range(3000, 0));
        ay0 = 18'(v);
        astep = 18'(200 + $urandom_range(300, 0));
    endtask

    task automatic wait_m_done(input int base, input int budget, input bit gate, output bit ok);
        int c;
        ok = 1'b0;
        c = 0;
        while (c < budget && !ok) begin
            if (gate) en = (c % 4 == 0);
            tick();
            c++;
            if (n_done_m > base) ok = 1'b1;
        end
        en = 1'b1;
    endtask

    task automatic wait_m_writes(input int n, input int budget, output bit ok);
        int c;
        ok = 1'b0;
        c = 0;
        while (c < budget && !ok) begin
            tick();
            c++;
            if (q_m.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic compare_m_frame(input string name);
        tests_run++;
        if (q_m.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s count: got %0d want %0d", name, q_m.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q_m.size(); i++) begin
            tests_run++;
            if (q_m[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s pixel %0d: got b%0d a%0d d%h want b%0d a%0d d%h", name, i,
                         q_m[i].bank, q_m[i].addr, q_m[i].data,
                         exp_q[i].bank, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({m_bank, m_addr, m_data, m_write, m_busy, m_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_m: got b%0d a%0d d%h w%b busy%b done%b want all 0",
                     m_bank, m_addr, m_data, m_write, m_busy, m_done);
        end
        tests_run++;
        if ({s_bank, s_addr, s_data, s_write, s_busy, s_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_s: outputs got nonzero want all 0");
        end
        tests_run++;
        if ({f_bank, f_addr, f_data, f_write, f_busy, f_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_f: outputs got nonzero want all 0");
        end
    endtask

    task automatic test_escape_small();
        int base, c;
        x0 = 18'h06000; y0 = '0; step = '0;
        build_exp(4, 2, 1, x0, y0, step);
        q_s.delete();
        base = n_done_s;
        pulse_start(0);
        c = 0;
        while (c < 300 && n_done_s == base) begin
            tick();
            c++;
        end
        tick();
        tests_run++;
        if (n_done_s != base + 1) begin
            tests_failed++;
            $display("FAIL escape_small done: got %0d want 1", n_done_s - base);
        end
        tests_run++;
        if (q_s.size() != 8) begin
            tests_failed++;
            $display("FAIL escape_small count: got %0d want 8", q_s.size());
        end
        for (int i = 0; i < q_s.size() && i < 8; i++) begin
            tests_run++;
            if (q_s[i] !== exp_q[i] || q_s[i].data !== 12'h11E) begin
                tests_failed++;
                $display("FAIL escape_small pixel %0d: got b%0d a%0d d%h want b%0d a%0d d11e",
                         i, q_s[i].bank, q_s[i].addr, q_s[i].data, exp_q[i].bank,
                         exp_q[i].addr);
            end
        end
    endtask

    task automatic test_inside_latency();
        int k;
        x0 = '0; y0 = '0; step = '0;
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        k = 0;
        while (k < 300 && !f_write) begin
            tick();
            k++;
        end
        // INIT, then MAX_ITER+1 ITER visits, then the WRITE edge raises o_write
        tests_run++;
        if (k != 63 + 3) begin
            tests_failed++;
            $display("FAIL inside_latency: got %0d cycles want %0d", k, 66);
        end
        tests_run++;
        if ({f_bank, f_addr, f_data, f_busy} !== {4'd0, 13'd0, 12'h000, 1'b1}) begin
            tests_failed++;
            $display("FAIL inside_first_write: got b%0d a%0d d%h busy%b want b0 a0 d000 busy1",
                     f_bank, f_addr, f_data, f_busy);
        end
        do_reset();
    endtask

    task automatic test_frame_random();
        int base;
        bit ok;
        rand_coords();
        x0 = ax0; y0 = ay0; step = astep;
        build_exp(4, 32, 16, ax0, ay0, astep);
        q_m.delete();
        base = n_done_m;
        pulse_start(1);
        wait_m_done(base, 128 * 70 + 100, 1'b0, ok);
        tick();
        tests_run++;
        if (!ok || n_done_m != base + 1) begin
            tests_failed++;
            $display("FAIL frame_done: got %0d pulses want 1", n_done_m - base);
        end
        compare_m_frame("frame_random");
        tests_run++;
        if (q_m.size() == 128 && {q_m[64].bank, q_m[64].addr, q_m[127].bank, q_m[127].addr}
                !== {4'd1, 13'd0, 4'd1, 13'd63}) begin
            tests_failed++;
            $display("FAIL frame_bank_edge: got b%0d a%0d / b%0d a%0d want b1 a0 / b1 a63",
                     q_m[64].bank, q_m[64].addr, q_m[127].bank, q_m[127].addr);
        end
        tests_run++;
        if (m_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_busy_after: got %b want 0", m_busy);
        end
    endtask

    task automatic test_enable_gating();
        int base, wide0;
        bit ok;
        x0 = ax0; y0 = ay0; step = astep;
        q_m.delete();
        base = n_done_m;
        wide0 = n_wide_m;
        pulse_start(1);
        wait_m_done(base, 4 * 128 * 70 + 400, 1'b1, ok);
        tick();
        tick();
        tests_run++;
        if (!ok || n_done_m != base + 1) begin
            tests_failed++;
            $display("FAIL gating_done: got %0d pulses want 1", n_done_m - base);
        end
        compare_m_frame("gating");
        tests_run++;
        if (n_wide_m != wide0) begin
            tests_failed++;
            $display("FAIL gating_write_width: got %0d long pulses want 0", n_wide_m - wide0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        rand_coords();
        x0 = ax0; y0 = ay0; step = astep;
        q_m.delete();
        pulse_start(1);
        wait_m_writes(100, 100 * 70 + 100, ok);
        rst = 1'b1;
        tick();
        tests_run++;
        if (!ok || {m_bank, m_addr, m_data, m_write, m_busy, m_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid outputs: got b%0d a%0d d%h w%b busy%b want all 0",
                     m_bank, m_addr, m_data, m_write, m_busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        tests_run++;
        if (q_m.size() != 100 || m_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid quiet: got %0d writes busy%b want 100 busy0",
                     q_m.size(), m_busy);
        end
        rand_coords();
        x0 = ax0; y0 = ay0; step = astep;
        build_exp(4, 32, 16, ax0, ay0, astep);
        q_m.delete();
        pulse_start(1);
        wait_m_writes(1, 200, ok);
        tests_run++;
        if (!ok || q_m[0] !== exp_q[0] || q_m[0].bank !== 4'd0 || q_m[0].addr !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_mid restart: got %0d writes first %h want %h",
                     q_m.size(), ok ? q_m[0] : '0, exp_q[0]);
        end
        do_reset();
    endtask

    task automatic test_start_busy();
        int base;
        bit ok;
        rand_coords();
        x0 = ax0; y0 = ay0; step = astep;
        build_exp(4, 32, 16, ax0, ay0, astep);
        q_m.delete();
        base = n_done_m;
        pulse_start(1);
        wait_m_writes(10, 10 * 70 + 100, ok);
        x0 = 18'($urandom); y0 = 18'($urandom); step = 18'($urandom_range(4000, 0));
        pulse_start(1);
        wait_m_done(base, 128 * 70 + 100, 1'b0, ok);
        for (int i = 0; i < 20; i++) tick();
        tests_run++;
        if (!ok || n_done_m != base + 1) begin
            tests_failed++;
            $display("FAIL start_busy done: got %0d pulses want 1", n_done_m - base);
        end
        compare_m_frame("start_busy");
        tests_run++;
        if (m_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_busy idle: got busy %b want 0", m_busy);
        end
    endtask

    task automatic test_full_addressing();
        int c;
        x0 = 18'h06000; y0 = '0; step = '0;
        q_f.delete();
        pulse_start(2);
        c = 0;
        while (c < 5121 * 4 + 200 && q_f.size() < 5121) begin
            tick();
            c++;
        end
        tests_run++;
        if (q_f.size() < 5121) begin
            tests_failed++;
            $display("FAIL full_progress: got %0d writes want 5121", q_f.size());
        end else begin
            tests_run++;
            if ({q_f[319].bank, q_f[319].addr, q_f[320].addr} !== {4'd0, 13'd319, 13'd320}) begin
                tests_failed++;
                $display("FAIL full_line_wrap: got b%0d a%0d a%0d want b0 a319 a320",
                         q_f[319].bank, q_f[319].addr, q_f[320].addr);
            end
            tests_run++;
            if ({q_f[5119].bank, q_f[5119].addr} !== {4'd0, 13'd5119}) begin
                tests_failed++;
                $display("FAIL full_bank_last: got b%0d a%0d want b0 a5119",
                         q_f[5119].bank, q_f[5119].addr);
            end
            tests_run++;
            if (q_f[5120] !== {4'd1, 13'd0, 12'h11E}) begin
                tests_failed++;
                $display("FAIL full_bank1_first: got b%0d a%0d d%h want b1 a0 d11e",
                         q_f[5120].bank, q_f[5120].addr, q_f[5120].data);
            end
        end
        do_reset();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b0; en = 1'b1;
        x0 = '0; y0 = '0; step = '0;
        s_start = 1'b0; m_start = 1'b0; f_start = 1'b0;
        test_reset();
        test_escape_small();
        test_inside_latency();
        test_frame_random();
        test_enable_gating();
        test_reset_mid();
        test_start_busy();
        test_full_addressing();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
